// File: rtl/rom_buf_pkg.sv
// Shared types and parameter defaults for the ROM line buffer.
//   state_e          : fill FSM states
//   DEF_AW           : default byte-address width of the ROM region
//   DEF_WAIT_STATES  : default extra ROM macro cycles per word
//   DEF_LINE_WORDS   : default words per buffered line
package rom_buf_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  localparam int unsigned DEF_AW          = 14;
  localparam int unsigned DEF_WAIT_STATES = 2;
  localparam int unsigned DEF_LINE_WORDS  = 4;

endpackage

// File: rtl/rom_line_buffer_if.sv
// Request/response bus between the AHB ROM controller and the line buffer.
//   req_cs    : read request (address phase)
//   req_addr  : word address of the request
//   flush     : invalidate the line buffer
//   rsp_ready : ready back to the controller (its HREADYOUT)
//   rsp_rdata : read data for the current data phase
interface rom_line_buffer_if #(
  parameter int unsigned AW = rom_buf_pkg::DEF_AW
) ();

  logic          req_cs;
  logic [AW-3:0] req_addr;
  logic          flush;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;

  modport master (output req_cs, req_addr, flush, input rsp_ready, rsp_rdata);
  modport slave  (input req_cs, req_addr, flush, output rsp_ready, rsp_rdata);

endinterface

// File: rtl/rom_line_store.sv
// Storage for one buffered ROM line: word array, tag and valid flag.
//   HCLK, HRESETn : clock, async active-low reset (clears valid and tag)
//   i_wr_*        : write one word of the line
//   i_set_valid   : mark line valid with tag i_set_tag
//   i_clr_valid   : invalidate the line (wins over set)
//   i_rd_idx      : combinational read index -> o_rd_data
//   o_tag/o_valid : current line tag and valid flag
module rom_line_store #(
  parameter int unsigned TW = 10,
  parameter int unsigned LW = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  i_wr_en,
  input  logic [$clog2(LW)-1:0] i_wr_idx,
  input  logic [31:0]           i_wr_data,
  input  logic                  i_set_valid,
  input  logic [TW-1:0]         i_set_tag,
  input  logic                  i_clr_valid,
  input  logic [$clog2(LW)-1:0] i_rd_idx,
  output logic [31:0]           o_rd_data,
  output logic [TW-1:0]         o_tag,
  output logic                  o_valid
);

  logic [31:0]   r_words [LW];
  logic [TW-1:0] r_tag;
  logic          r_valid;

  // Data words need no reset; valid guards them.
  always_ff @(posedge HCLK) begin
    if (i_wr_en) r_words[i_wr_idx] <= i_wr_data;
  end

  // Tag and valid flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_tag   <= '0;
      r_valid <= 1'b0;
    end else if (i_clr_valid) begin
      r_valid <= 1'b0;
    end else if (i_set_valid) begin
      r_tag   <= i_set_tag;
      r_valid <= 1'b1;
    end
  end

  assign o_rd_data = r_words[i_rd_idx];
  assign o_tag     = r_tag;
  assign o_valid   = r_valid;

endmodule

// File: rtl/rom_line_buffer.sv
// Single-line read buffer in front of a slow ROM macro. Hits return with
// zero wait states; a miss fetches the whole line word by word.
//   HCLK, HRESETn      : clock, async active-low reset
//   bus                : controller request/response (slave side)
//   mem_cs/mem_addr    : ROM macro select and word address
//   mem_rdata          : ROM macro read data
//   hit_cnt/miss_cnt   : saturating access statistics
module rom_line_buffer
  import rom_buf_pkg::*;
#(
  parameter int unsigned AW          = DEF_AW,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
  parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  rom_line_buffer_if.slave bus,
  output logic             mem_cs,
  output logic [AW-3:0]    mem_addr,
  input  logic [31:0]      mem_rdata,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
);

  localparam int unsigned IW  = $clog2(LINE_WORDS);
  localparam int unsigned TW  = AW - 2 - IW;
  localparam int unsigned WCW = 4;

  state_e          r_state, w_state_nxt;
  logic [TW-1:0]   r_tag;
  logic [IW-1:0]   r_idx, r_word;
  logic [WCW-1:0]  r_wait;
  logic            r_flush_pend, r_rsp_ready, r_mem_cs;
  logic [31:0]     r_rsp_rdata;
  logic [AW-3:0]   r_mem_addr;
  logic [15:0]     r_hit_cnt, r_miss_cnt;

  logic [TW-1:0]   w_req_tag, w_line_tag;
  logic [IW-1:0]   w_req_idx, w_rd_idx;
  logic [31:0]     w_rd_data;
  logic            w_line_valid, w_flush_eff, w_accept, w_hit, w_miss;
  logic            w_capture, w_last, w_clr_valid;

  assign w_req_tag   = bus.req_addr[AW-3:IW];
  assign w_req_idx   = bus.req_addr[IW-1:0];
  // A flush pending from the last fill acts like a live flush in IDLE.
  assign w_flush_eff = bus.flush | r_flush_pend;
  assign w_accept    = (r_state == ST_IDLE) && bus.req_cs && r_rsp_ready;
  assign w_hit       = w_accept && w_line_valid && !w_flush_eff && (w_line_tag == w_req_tag);
  assign w_miss      = w_accept && !w_hit;
  assign w_capture   = (r_state == ST_FILL) && (r_wait == WCW'(WAIT_STATES));
  assign w_last      = w_capture && (r_word == IW'(LINE_WORDS - 1));
  assign w_clr_valid = (r_state == ST_IDLE) && w_flush_eff;
  assign w_rd_idx    = (r_state == ST_IDLE) ? w_req_idx : r_idx;

  rom_line_store #(.TW(TW), .LW(LINE_WORDS)) u_store (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .i_wr_en     (w_capture),
    .i_wr_idx    (r_word),
    .i_wr_data   (mem_rdata),
    .i_set_valid (w_last),
    .i_set_tag   (r_tag),
    .i_clr_valid (w_clr_valid),
    .i_rd_idx    (w_rd_idx),
    .o_rd_data   (w_rd_data),
    .o_tag       (w_line_tag),
    .o_valid     (w_line_valid)
  );

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_miss) w_state_nxt = ST_FILL;
      ST_FILL: if (w_last) w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: response, ROM sequencing, pending flush and statistics.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_tag        <= '0;
      r_idx        <= '0;
      r_word       <= '0;
      r_wait       <= '0;
      r_flush_pend <= 1'b0;
      r_rsp_ready  <= 1'b1;
      r_rsp_rdata  <= '0;
      r_mem_cs     <= 1'b0;
      r_mem_addr   <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      if (w_hit) begin
        r_rsp_rdata <= w_rd_data;
        if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      end
      if (w_miss) begin
        r_tag       <= w_req_tag;
        r_idx       <= w_req_idx;
        r_word      <= '0;
        r_wait      <= '0;
        r_mem_cs    <= 1'b1;
        r_mem_addr  <= {w_req_tag, IW'(0)};
        r_rsp_ready <= 1'b0;
        if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
      end
      if (r_state == ST_FILL) begin
        if (bus.flush) r_flush_pend <= 1'b1;
        if (w_capture) begin
          r_wait <= '0;
          if (w_last) begin
            r_mem_cs    <= 1'b0;
            r_rsp_ready <= 1'b1;
            // Requested word may be the one arriving on this very edge.
            r_rsp_rdata <= (r_idx == r_word) ? mem_rdata : w_rd_data;
          end else begin
            r_word     <= r_word + IW'(1);
            r_mem_addr <= {r_tag, r_word + IW'(1)};
          end
        end else begin
          r_wait <= r_wait + WCW'(1);
        end
      end else if (w_flush_eff) begin
        r_flush_pend <= 1'b0;
      end
    end
  end

  assign bus.rsp_ready = r_rsp_ready;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign mem_cs        = r_mem_cs;
  assign mem_addr      = r_mem_addr;
  assign hit_cnt       = r_hit_cnt;
  assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_rom_line_buffer.sv
// Bench for rom_line_buffer: default instance plus a WAIT_STATES=0,
// LINE_WORDS=2 instance. Expected read data is queued when a request is
// driven and compared when the response arrives.
module tb_rom_line_buffer;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  rom_line_buffer_if #(.AW(14)) bus  ();
  rom_line_buffer_if #(.AW(14)) bus2 ();

  logic        mem_cs, mem2_cs;
  logic [11:0] mem_addr, mem2_addr;
  logic [31:0] mem_rdata, mem2_rdata;
  logic [15:0] hit_cnt, miss_cnt, hit2_cnt, miss2_cnt;

  function automatic logic [31:0] rom_f(input logic [11:0] a);
    return {8'h5A, a, ~a};
  endfunction

  assign mem_rdata  = mem_cs  ? rom_f(mem_addr)  : 32'hDEAD_BEEF;
  assign mem2_rdata = mem2_cs ? rom_f(mem2_addr) : 32'hDEAD_BEEF;

  rom_line_buffer #(.AW(14), .WAIT_STATES(2), .LINE_WORDS(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  rom_line_buffer #(.AW(14), .WAIT_STATES(0), .LINE_WORDS(2)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2),
    .mem_cs(mem2_cs), .mem_addr(mem2_addr), .mem_rdata(mem2_rdata),
    .hit_cnt(hit2_cnt), .miss_cnt(miss2_cnt)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned m_hit    = 0;
  int unsigned m_miss   = 0;
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.rsp_ready), 32'd1);
    check({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "_mem_cs"}, 32'(mem_cs), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
    check({tag, "_miss_cnt"}, 32'(miss_cnt), 32'd0);
  endtask

  // One read on the default instance, starting at a negedge with ready=1.
  // flush_at: fill cycle to pulse flush (-1 = with the request, 0 = none).
  // rst_at:   fill cycle to drop HRESETn (0 = none).
  task automatic rd(input logic [11:0] addr, input int exp_low, input int flush_at, input int rst_at);
    int          lows;
    bit          aborted;
    logic [11:0] base;
    logic [31:0] exp;
    base = {addr[11:2], 2'b00};
    bus.req_cs   = 1'b1;
    bus.req_addr = addr;
    if (flush_at < 0) bus.flush = 1'b1;
    sb.push_back(rom_f(addr));
    @(negedge HCLK);
    bus.req_cs = 1'b0;
    bus.flush  = 1'b0;
    lows    = 0;
    aborted = 1'b0;
    while (!bus.rsp_ready && lows < 200 && !aborted) begin
      lows++;
      check("fill_mem_cs", 32'(mem_cs), 32'd1);
      check("fill_mem_addr", 32'(mem_addr), 32'(base + 12'((lows - 1) / 3)));
      if (lows == flush_at) bus.flush = 1'b1;
      if (lows == rst_at) begin
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("midfill_rst");
        m_hit  = 0;
        m_miss = 0;
        void'(sb.pop_front());
        @(negedge HCLK);
        HRESETn = 1'b1;
        aborted = 1'b1;
      end else begin
        @(negedge HCLK);
        bus.flush = 1'b0;
      end
    end
    if (!aborted) begin
      check("low_cycles", 32'(lows), 32'(exp_low));
      if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else begin
        exp = sb.pop_front();
        check("rdata", bus.rsp_rdata, exp);
      end
      if (exp_low == 0) begin
        check("hit_mem_cs", 32'(mem_cs), 32'd0);
        m_hit++;
      end else begin
        m_miss++;
      end
      check("hit_cnt", 32'(hit_cnt), 32'(m_hit));
      check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    end
  endtask

  // Read on the WAIT_STATES=0, LINE_WORDS=2 instance.
  task automatic rd2(input logic [11:0] addr, input int exp_low, input logic [15:0] exp_miss);
    int lows;
    bus2.req_cs   = 1'b1;
    bus2.req_addr = addr;
    @(negedge HCLK);
    bus2.req_cs = 1'b0;
    lows = 0;
    while (!bus2.rsp_ready && lows < 50) begin
      lows++;
      @(negedge HCLK);
    end
    check("d2_low_cycles", 32'(lows), 32'(exp_low));
    check("d2_rdata", bus2.rsp_rdata, rom_f(addr));
    check("d2_miss_cnt", 32'(miss2_cnt), 32'(exp_miss));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_cs = 1'b0; bus.req_addr = '0; bus.flush = 1'b0;
    bus2.req_cs = 1'b0; bus2.req_addr = '0; bus2.flush = 1'b0;
    repeat (3) @(negedge HCLK);
    check_reset_outputs("reset");
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Cold miss, then back-to-back hits in the same line.
    rd(12'h010, 12, 0, 0);
    rd(12'h011, 0, 0, 0);
    rd(12'h012, 0, 0, 0);
    rd(12'h013, 0, 0, 0);
    @(negedge HCLK);
    check("rdata_hold", bus.rsp_rdata, rom_f(12'h013));
    check("ready_hold", 32'(bus.rsp_ready), 32'd1);

    // Line replacement.
    rd(12'h022, 12, 0, 0);
    rd(12'h020, 0, 0, 0);
    rd(12'h010, 12, 0, 0);

    // Flush during fill: data still delivered, same line then misses.
    rd(12'h031, 12, 5, 0);
    rd(12'h030, 12, 0, 0);
    rd(12'h033, 0, 0, 0);

    // Flush in IDLE, and flush together with an accepted request.
    bus.flush = 1'b1;
    @(negedge HCLK);
    bus.flush = 1'b0;
    rd(12'h032, 12, 0, 0);
    rd(12'h031, 12, -1, 0);
    rd(12'h030, 0, 0, 0);

    // Reset in the middle of a fill.
    rd(12'h043, 12, 0, 7);
    rd(12'h043, 12, 0, 0);
    rd(12'h041, 0, 0, 0);

    // Small instance: timing and counter saturation.
    rd2(12'h105, 2, 16'd1);
    rd2(12'h104, 0, 16'd1);
    force dut2.r_miss_cnt = 16'hFFFF;
    @(negedge HCLK);
    release dut2.r_miss_cnt;
    @(negedge HCLK);
    rd2(12'h10A, 2, 16'hFFFF);
    rd2(12'h200, 2, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_line_buffer.md
ROM_LINE_BUFFER -- requirements
Module: rom_line_buffer

Interface
REQ-001 SHALL have parameter AW, default 14, byte-address width of the ROM region; the word address is AW-2 bits.
REQ-002 SHALL have parameter WAIT_STATES, default 2, extra ROM macro cycles per word read (0..15).
REQ-003 SHALL have parameter LINE_WORDS, default 4, words per buffered line; power of two, 2..16.
REQ-004 SHALL have port HCLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_cs  input  1  read request from the AHB ROM controller (address phase).
REQ-007 SHALL have port req_addr  input  AW-2  word address of the request.
REQ-008 SHALL have port rsp_ready  output  1  ready to the controller; used as its HREADYOUT.
REQ-009 SHALL have port rsp_rdata  output  32  read data for the current data phase.
REQ-010 SHALL have port flush  input  1  invalidate the line buffer.
REQ-011 SHALL have ports mem_cs  output  1, mem_addr  output  AW-2, and mem_rdata  input  32, driving the slow ROM macro.
REQ-012 SHALL have ports hit_cnt and miss_cnt, each output 16, saturating access statistics.

Function
REQ-013 SHALL accept a request only on a cycle where req_cs=1 and rsp_ready=1, and SHALL then register req_addr.
REQ-014 SHALL split the word address into tag (upper AW-2-log2(LINE_WORDS) bits) and word index (lower log2(LINE_WORDS) bits).
REQ-015 SHALL treat a request as a hit when the line valid flag is 1 and the stored tag equals the request tag.
REQ-016 On a hit, SHALL keep rsp_ready=1 in the next cycle, drive rsp_rdata with the indexed buffer word, and increment hit_cnt (zero wait states).
REQ-017 On a miss, SHALL enter FILL the next cycle, drive rsp_ready=0, and increment miss_cnt.
REQ-018 FSM states SHALL be IDLE and FILL: IDLE->FILL on an accepted miss; FILL->IDLE after the last word is captured; all other cases hold.
REQ-019 In FILL, SHALL fetch words 0..LINE_WORDS-1 of the missed line in ascending order.
REQ-020 For each fetched word, SHALL hold mem_cs=1 and mem_addr={tag,word} for WAIT_STATES+1 cycles, then capture mem_rdata on the final edge of that window.
REQ-021 rsp_ready SHALL be 0 for exactly LINE_WORDS*(WAIT_STATES+1) cycles per miss; defaults give 12.
REQ-022 When the last word is captured, SHALL set the stored tag and valid=1; in the first IDLE cycle, SHALL drive rsp_ready=1 with the requested word on rsp_rdata.
REQ-023 rsp_rdata SHALL hold its last value while no new request is accepted.
REQ-024 mem_cs SHALL be 0 in IDLE.
REQ-025 req_cs while rsp_ready=0 SHALL be ignored; the controller holds the address phase per AHB rules.
REQ-026 flush in IDLE SHALL clear valid on the next edge.
REQ-027 If flush and an accepted request occur in the same cycle, SHALL treat that request as a miss.
REQ-028 flush during FILL SHALL be latched as pending; the fill SHALL complete and deliver its word, and valid SHALL then be cleared in the first IDLE cycle.
REQ-029 hit_cnt and miss_cnt SHALL saturate at 16'hFFFF and SHALL not wrap.

Reset
REQ-030 While HRESETn=0, SHALL force: state=IDLE, valid=0, pending flush=0, rsp_ready=1, rsp_rdata=0, mem_cs=0, mem_addr=0, both counters=0.
REQ-031 Reset asserted mid-FILL SHALL abort the fill, leaving the buffer invalid; the next request after release SHALL be a miss.

Structure
REQ-032 Package rom_buf_pkg SHALL hold the FSM state enum and the default values of the AW, WAIT_STATES and LINE_WORDS parameters.
REQ-033 Line storage (word array, tag, valid) SHALL be sub-module rom_line_store; FSM, wait counter and statistics SHALL live in the top module.

Verification
REQ-034 Reset then read 0x010 -> rsp_ready low 12 cycles, mem_addr steps 0x010..0x013 in 3-cycle windows, correct data returned, miss_cnt=1.
REQ-035 After REQ-034, back-to-back reads 0x011, 0x012, 0x013 -> zero wait states, correct data each cycle, hit_cnt=3, mem_cs stays 0.
REQ-036 Read 0x020 after line 0x010 is loaded -> refill of 0x020..0x023; a subsequent read of 0x010 misses again.
REQ-037 Assert flush at the 5th FILL cycle -> fill completes and data is returned; the next same-line read misses.
REQ-038 Drop HRESETn at the 7th FILL cycle -> outputs at reset values immediately, counters 0; the first read after release misses.
REQ-039 With WAIT_STATES=0 and LINE_WORDS=2, a miss -> rsp_ready low exactly 2 cycles; force miss_cnt to 0xFFFF then miss -> stays 0xFFFF.
